// File: rtl/virtual_uart_fifo_pkg.sv
// Shared register map, bit positions and response codes for the virtual UART.
// Also holds the helper that packs the STATUS word.
package virtual_uart_fifo_pkg;

  localparam logic [7:0] VUART_RX_OFFSET       = 8'h00;
  localparam logic [7:0] VUART_TX_OFFSET       = 8'h04;
  localparam logic [7:0] VUART_STATUS_OFFSET   = 8'h08;
  localparam logic [7:0] VUART_CONTROL_OFFSET  = 8'h0C;
  localparam logic [7:0] VUART_HOST_ACK_OFFSET = 8'h10;

  // Word index within the 32-byte window, i.e. address bits [4:2]
  typedef enum logic [2:0] {
    REG_RX       = VUART_RX_OFFSET[4:2],
    REG_TX       = VUART_TX_OFFSET[4:2],
    REG_STATUS   = VUART_STATUS_OFFSET[4:2],
    REG_CONTROL  = VUART_CONTROL_OFFSET[4:2],
    REG_HOST_ACK = VUART_HOST_ACK_OFFSET[4:2]
  } reg_sel_e;

  localparam int STATUS_RX_VALID = 0;
  localparam int STATUS_RX_FULL  = 1;
  localparam int STATUS_TX_EMPTY = 2;
  localparam int STATUS_TX_FULL  = 3;
  localparam int STATUS_INTR_EN  = 4;
  localparam int STATUS_OVERRUN  = 5;

  localparam int CTRL_FLUSH_TX = 0;
  localparam int CTRL_FLUSH_RX = 1;
  localparam int CTRL_INTR_EN  = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] pack_status(
    input logic       rx_valid,
    input logic       rx_full,
    input logic       tx_empty,
    input logic       tx_full,
    input logic       intr_en,
    input logic       overrun,
    input logic [7:0] rx_level,
    input logic [7:0] tx_level
  );
    logic [31:0] word;
    word                  = 32'h0000_0000;
    word[STATUS_RX_VALID] = rx_valid;
    word[STATUS_RX_FULL]  = rx_full;
    word[STATUS_TX_EMPTY] = tx_empty;
    word[STATUS_TX_FULL]  = tx_full;
    word[STATUS_INTR_EN]  = intr_en;
    word[STATUS_OVERRUN]  = overrun;
    word[23:16]           = rx_level;
    word[31:24]           = tx_level;
    return word;
  endfunction

endpackage

// File: rtl/virtual_uart_fifo_if.sv
// AXI-lite bundle between the bus fabric and the virtual UART.
interface virtual_uart_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/vuart_sync_fifo.sv
// Single-clock show-ahead FIFO with flush and level output.
// Push on full is allowed only when a pop frees the slot in the same cycle.
module vuart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock_i,
  input  logic                     reset_ni,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [WIDTH-1:0]         rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (level_r == FULL_LEVEL);
  assign empty     = (level_r == LW'(0));
  assign level     = level_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Pointer and level bookkeeping; flush discards everything at once
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clock_i) begin
    if (do_push_s && !flush) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

endmodule

// File: rtl/virtual_uart_fifo.sv
// Virtual UART: AXI-lite slave exposing RX/TX FIFOs, status, control and
// two sticky interrupts (core side and XDMA host side).
module virtual_uart_fifo
  import virtual_uart_fifo_pkg::*;
#(
  parameter int LOCAL_DATA_WIDTH = 32,
  parameter int LOCAL_ADDR_WIDTH = 32,
  parameter int LOCAL_ID_WIDTH   = 32,
  parameter int RX_FIFO_DEPTH    = 16,
  parameter int TX_FIFO_DEPTH    = 16,
  parameter int CHAR_WIDTH       = 8
) (
  input  logic                clock_i,
  input  logic                reset_ni,
  output logic                int_core_o,
  output logic                int_xdma_o,
  input  logic [1:0]          int_ack_i,
  virtual_uart_fifo_if.slave  s_axilite
);
  localparam bit CFG_OK = (LOCAL_DATA_WIDTH == 32) && (LOCAL_ADDR_WIDTH >= 5) &&
                          (LOCAL_ID_WIDTH > 0) && (CHAR_WIDTH >= 5) && (CHAR_WIDTH <= 8) &&
                          (RX_FIFO_DEPTH >= 2) && (RX_FIFO_DEPTH <= 128) &&
                          (TX_FIFO_DEPTH >= 2) && (TX_FIFO_DEPTH <= 128);
  localparam int RX_LW = $clog2(RX_FIFO_DEPTH) + 1;
  localparam int TX_LW = $clog2(TX_FIFO_DEPTH) + 1;

  if (!CFG_OK) begin : g_invalid_config
  end

  logic                        awready_r, arready_r, bvalid_r, rvalid_r;
  logic [1:0]                  bresp_r, rresp_r, bresp_s, rresp_s;
  logic [LOCAL_DATA_WIDTH-1:0] rdata_r, rdata_s;
  logic                        intr_en_r, overrun_r, int_core_r, int_xdma_r;

  logic                  wr_acc_s, rd_acc_s;
  reg_sel_e              wr_sel_s, rd_sel_s;
  logic [CHAR_WIDTH-1:0] wr_char_s, rx_rdata_s, tx_rdata_s;
  logic                  rx_push_req_s, rx_push_ok_s, rx_pop_s, rx_flush_s;
  logic                  tx_push_req_s, tx_push_ok_s, tx_pop_s, tx_flush_s;
  logic                  rx_full_s, rx_empty_s, tx_full_s, tx_empty_s;
  logic [RX_LW-1:0]      rx_level_s;
  logic [TX_LW-1:0]      tx_level_s;
  logic                  ctrl_wr_s, host_ack_s, status_rd_s, tx_to_empty_s;
  logic                  overrun_set_s, core_set_s;

  assign wr_acc_s  = awready_r && s_axilite.awvalid && s_axilite.wvalid;
  assign rd_acc_s  = arready_r && s_axilite.arvalid;
  assign wr_sel_s  = reg_sel_e'(s_axilite.awaddr[4:2]);
  assign rd_sel_s  = reg_sel_e'(s_axilite.araddr[4:2]);
  assign wr_char_s = s_axilite.wdata[CHAR_WIDTH-1:0];

  assign rx_push_req_s = wr_acc_s && (wr_sel_s == REG_RX);
  assign tx_push_req_s = wr_acc_s && (wr_sel_s == REG_TX);
  assign rx_pop_s      = rd_acc_s && (rd_sel_s == REG_RX) && !rx_empty_s;
  assign tx_pop_s      = rd_acc_s && (rd_sel_s == REG_TX) && !tx_empty_s;
  // A same-cycle pop frees the slot, so a push to a full FIFO still lands
  assign rx_push_ok_s  = rx_push_req_s && (!rx_full_s || rx_pop_s);
  assign tx_push_ok_s  = tx_push_req_s && (!tx_full_s || tx_pop_s);

  assign ctrl_wr_s     = wr_acc_s && (wr_sel_s == REG_CONTROL);
  assign host_ack_s    = wr_acc_s && (wr_sel_s == REG_HOST_ACK);
  assign status_rd_s   = rd_acc_s && (rd_sel_s == REG_STATUS);
  assign rx_flush_s    = ctrl_wr_s && s_axilite.wdata[CTRL_FLUSH_RX];
  assign tx_flush_s    = ctrl_wr_s && s_axilite.wdata[CTRL_FLUSH_TX];

  assign overrun_set_s = (rx_push_req_s && !rx_push_ok_s) || (tx_push_req_s && !tx_push_ok_s);
  assign tx_to_empty_s = tx_pop_s && !tx_push_ok_s && (tx_level_s == TX_LW'(1));
  assign core_set_s    = intr_en_r && (rx_push_ok_s || tx_to_empty_s);

  vuart_sync_fifo #(.WIDTH(CHAR_WIDTH), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clock_i (clock_i),
    .reset_ni(reset_ni),
    .push    (rx_push_ok_s),
    .pop     (rx_pop_s),
    .flush   (rx_flush_s),
    .wdata   (wr_char_s),
    .full    (rx_full_s),
    .empty   (rx_empty_s),
    .level   (rx_level_s),
    .rdata   (rx_rdata_s)
  );

  vuart_sync_fifo #(.WIDTH(CHAR_WIDTH), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clock_i (clock_i),
    .reset_ni(reset_ni),
    .push    (tx_push_ok_s),
    .pop     (tx_pop_s),
    .flush   (tx_flush_s),
    .wdata   (wr_char_s),
    .full    (tx_full_s),
    .empty   (tx_empty_s),
    .level   (tx_level_s),
    .rdata   (tx_rdata_s)
  );

  // Write response for the register addressed by the accepted write
  always_comb begin
    bresp_s = RESP_SLVERR;
    case (wr_sel_s)
      REG_RX:       bresp_s = (rx_full_s && !rx_pop_s) ? RESP_SLVERR : RESP_OKAY;
      REG_TX:       bresp_s = (tx_full_s && !tx_pop_s) ? RESP_SLVERR : RESP_OKAY;
      REG_STATUS:   bresp_s = RESP_OKAY;
      REG_CONTROL:  bresp_s = RESP_OKAY;
      REG_HOST_ACK: bresp_s = RESP_OKAY;
      default:      bresp_s = RESP_SLVERR;
    endcase
  end

  // Read data mux; empty FIFOs read as zero with OKAY
  always_comb begin
    rdata_s = '0;
    rresp_s = RESP_OKAY;
    case (rd_sel_s)
      REG_RX: begin
        if (!rx_empty_s) rdata_s[CHAR_WIDTH-1:0] = rx_rdata_s;
        else             rdata_s = '0;
      end
      REG_TX: begin
        if (!tx_empty_s) rdata_s[CHAR_WIDTH-1:0] = tx_rdata_s;
        else             rdata_s = '0;
      end
      REG_STATUS: rdata_s = pack_status(!rx_empty_s, rx_full_s, tx_empty_s, tx_full_s,
                                        intr_en_r, overrun_r, 8'(rx_level_s), 8'(tx_level_s));
      REG_CONTROL, REG_HOST_ACK: rdata_s = '0;
      default: begin
        rdata_s = '0;
        rresp_s = RESP_SLVERR;
      end
    endcase
  end

  // Bus handshakes, control state and interrupts; set beats clear
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      awready_r  <= 1'b0;
      arready_r  <= 1'b0;
      bvalid_r   <= 1'b0;
      rvalid_r   <= 1'b0;
      bresp_r    <= RESP_OKAY;
      rresp_r    <= RESP_OKAY;
      rdata_r    <= '0;
      intr_en_r  <= 1'b0;
      overrun_r  <= 1'b0;
      int_core_r <= 1'b0;
      int_xdma_r <= 1'b0;
    end else begin
      awready_r <= s_axilite.awvalid && s_axilite.wvalid && !bvalid_r && !awready_r;
      arready_r <= s_axilite.arvalid && !rvalid_r && !arready_r;

      if (wr_acc_s) begin
        bvalid_r <= 1'b1;
        bresp_r  <= bresp_s;
      end else if (s_axilite.bready) begin
        bvalid_r <= 1'b0;
      end

      if (rd_acc_s) begin
        rvalid_r <= 1'b1;
        rresp_r  <= rresp_s;
        rdata_r  <= rdata_s;
      end else if (s_axilite.rready) begin
        rvalid_r <= 1'b0;
      end

      if (ctrl_wr_s) intr_en_r <= s_axilite.wdata[CTRL_INTR_EN];

      if (overrun_set_s)    overrun_r <= 1'b1;
      else if (status_rd_s) overrun_r <= 1'b0;

      if (core_set_s)        int_core_r <= 1'b1;
      else if (int_ack_i[0]) int_core_r <= 1'b0;

      if (tx_push_ok_s)                     int_xdma_r <= 1'b1;
      else if (host_ack_s || int_ack_i[1])  int_xdma_r <= 1'b0;
    end
  end

  assign s_axilite.awready = awready_r;
  assign s_axilite.wready  = awready_r;
  assign s_axilite.bvalid  = bvalid_r;
  assign s_axilite.bresp   = bresp_r;
  assign s_axilite.arready = arready_r;
  assign s_axilite.rvalid  = rvalid_r;
  assign s_axilite.rresp   = rresp_r;
  assign s_axilite.rdata   = rdata_r;
  assign int_core_o        = int_core_r;
  assign int_xdma_o        = int_xdma_r;

endmodule

// File: tb/tb_virtual_uart_fifo.sv
// Directed self-checking bench for virtual_uart_fifo with default parameters.
module tb_virtual_uart_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] int_ack = 2'b00;
  logic       int_core, int_xdma;
  int         compared = 0;
  int         mismatched = 0;

  virtual_uart_fifo_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  virtual_uart_fifo dut (
    .clock_i   (clk),
    .reset_ni  (rst_n),
    .int_core_o(int_core),
    .int_xdma_o(int_xdma),
    .int_ack_i (int_ack),
    .s_axilite (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_idle();
    bus.awaddr = 32'h0; bus.awvalid = 1'b0; bus.wdata = 32'h0; bus.wvalid = 1'b0;
    bus.bready = 1'b1;  bus.araddr = 32'h0; bus.arvalid = 1'b0; bus.rready = 1'b1;
  endtask

  task automatic timeout_fail(input string what);
    compared++; mismatched++;
    $display("FAIL %s: handshake timeout, got no response, required one within 20 cycles", what);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp);
    int n;
    @(negedge clk);
    bus.awaddr = addr; bus.wdata = data; bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    n = 0;
    while (!bus.awready && n < 20) begin @(negedge clk); n++; end
    if (!bus.awready) begin
      timeout_fail("write_accept"); bus.awvalid = 1'b0; bus.wvalid = 1'b0; resp = 2'b11; return;
    end
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 20) begin @(negedge clk); n++; end
    if (!bus.bvalid) begin timeout_fail("write_resp"); resp = 2'b11; return; end
    resp = bus.bresp;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    @(negedge clk);
    bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
    n = 0;
    while (!bus.arready && n < 20) begin @(negedge clk); n++; end
    if (!bus.arready) begin
      timeout_fail("read_accept"); bus.arvalid = 1'b0; data = 32'hDEAD_BEEF; resp = 2'b11; return;
    end
    @(negedge clk);
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 20) begin @(negedge clk); n++; end
    if (!bus.rvalid) begin timeout_fail("read_resp"); data = 32'hDEAD_BEEF; resp = 2'b11; return; end
    data = bus.rdata; resp = bus.rresp;
  endtask

  task automatic axi_wr_rd(input logic [31:0] waddr, input logic [31:0] wdat, input logic [31:0] raddr,
                           output logic [1:0] bresp, output logic [31:0] rdat, output logic [1:0] rresp);
    int n;
    @(negedge clk);
    bus.awaddr = waddr; bus.wdata = wdat; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    bus.araddr = raddr; bus.arvalid = 1'b1;
    n = 0;
    while (!(bus.awready && bus.arready) && n < 20) begin @(negedge clk); n++; end
    if (!(bus.awready && bus.arready)) begin
      timeout_fail("joint_accept");
      bus_idle(); bresp = 2'b11; rresp = 2'b11; rdat = 32'hDEAD_BEEF; return;
    end
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    n = 0;
    while (!(bus.bvalid && bus.rvalid) && n < 20) begin @(negedge clk); n++; end
    if (!(bus.bvalid && bus.rvalid)) begin
      timeout_fail("joint_resp"); bresp = 2'b11; rresp = 2'b11; rdat = 32'hDEAD_BEEF; return;
    end
    bresp = bus.bresp; rdat = bus.rdata; rresp = bus.rresp;
  endtask

  task automatic pulse_ack(input logic [1:0] val);
    @(negedge clk); int_ack = val;
    @(negedge clk); int_ack = 2'b00;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    bus_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.bresp, bus.rresp} !== 9'b0 ||
        bus.rdata !== 32'h0 || int_core !== 1'b0 || int_xdma !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: got aw%b w%b b%b ar%b r%b bresp%b rresp%b rdata=%h ic%b ix%b, required all 0",
               bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.bresp, bus.rresp,
               bus.rdata, int_core, int_xdma);
    end
    rst_n = 1'b1;
    axi_read(32'h08, d, r);
    compared++;
    if (d !== 32'h0000_0004 || r !== 2'b00) begin
      mismatched++; $display("FAIL reset_status: got %h/%b required 00000004/00", d, r);
    end
  endtask

  task automatic test_tx_path();
    logic [31:0] d; logic [1:0] r;
    logic [7:0] chars [3];
    chars[0] = 8'h41; chars[1] = 8'h42; chars[2] = 8'h43;
    axi_write(32'h0C, 32'h10, r);
    compared++;
    if (r !== 2'b00) begin mismatched++; $display("FAIL ctrl_write_resp: got %b required 00", r); end
    for (int i = 0; i < 3; i++) begin
      axi_write(32'h04, {24'h0, chars[i]}, r);
      compared++;
      if (r !== 2'b00) begin mismatched++; $display("FAIL tx_push_resp[%0d]: got %b required 00", i, r); end
    end
    compared++;
    if (int_xdma !== 1'b1 || int_core !== 1'b0) begin
      mismatched++; $display("FAIL tx_push_irqs: got xdma=%b core=%b required 1/0", int_xdma, int_core);
    end
    axi_read(32'h08, d, r);
    compared++;
    if (d !== 32'h0300_0010) begin mismatched++; $display("FAIL tx_status: got %h required 03000010", d); end
    for (int i = 0; i < 3; i++) begin
      axi_read(32'h04, d, r);
      compared++;
      if (d !== {24'h0, chars[i]} || r !== 2'b00) begin
        mismatched++; $display("FAIL tx_pop[%0d]: got %h/%b required %h/00", i, d, r, chars[i]);
      end
      compared++;
      if (int_core !== (i == 2)) begin
        mismatched++; $display("FAIL core_irq_after_pop[%0d]: got %b required %b", i, int_core, (i == 2));
      end
    end
    axi_write(32'h10, 32'h0, r);
    compared++;
    if (int_xdma !== 1'b0 || r !== 2'b00) begin
      mismatched++; $display("FAIL host_ack: got xdma=%b resp=%b required 0/00", int_xdma, r);
    end
    pulse_ack(2'b01);
    compared++;
    if (int_core !== 1'b0) begin mismatched++; $display("FAIL core_ack: got %b required 0", int_core); end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] d; logic [1:0] r;
    int bad;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      axi_write(32'h00, 32'h30 + i, r);
      if (r !== 2'b00) bad++;
    end
    compared++;
    if (bad != 0) begin mismatched++; $display("FAIL rx_fill_resp: got %0d errors required 0", bad); end
    axi_write(32'h00, 32'h99, r);
    compared++;
    if (r !== 2'b10) begin mismatched++; $display("FAIL rx_overflow_resp: got %b required 10", r); end
    axi_read(32'h08, d, r);
    compared++;
    if (d !== 32'h0010_0037) begin mismatched++; $display("FAIL overrun_status1: got %h required 00100037", d); end
    axi_read(32'h08, d, r);
    compared++;
    if (d !== 32'h0010_0017) begin mismatched++; $display("FAIL overrun_status2: got %h required 00100017", d); end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      axi_read(32'h00, d, r);
      if (d !== 32'h30 + i) begin
        bad++; $display("FAIL rx_drain[%0d]: got %h required %h", i, d, 32'h30 + i);
      end
    end
    compared++;
    if (bad != 0) mismatched++;
    axi_read(32'h00, d, r);
    compared++;
    if (d !== 32'h0 || r !== 2'b00) begin mismatched++; $display("FAIL rx_empty_read: got %h/%b required 0/00", d, r); end
    pulse_ack(2'b11);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] br, rr;
    int bad;
    for (int i = 0; i < 16; i++) axi_write(32'h04, 32'h50 + i, br);
    axi_wr_rd(32'h04, 32'h7A, 32'h04, br, d, rr);
    compared++;
    if (br !== 2'b00 || d !== 32'h50 || rr !== 2'b00) begin
      mismatched++; $display("FAIL full_joint: got bresp=%b rdata=%h rresp=%b required 00/00000050/00", br, d, rr);
    end
    axi_read(32'h08, d, rr);
    compared++;
    if (d !== 32'h1000_0018) begin mismatched++; $display("FAIL full_joint_status: got %h required 10000018", d); end
    bad = 0;
    for (int i = 1; i < 17; i++) begin
      axi_read(32'h04, d, rr);
      if (d !== ((i == 16) ? 32'h7A : 32'h50 + i)) begin
        bad++; $display("FAIL tx_order[%0d]: got %h required %h", i, d, (i == 16) ? 32'h7A : 32'h50 + i);
      end
    end
    compared++;
    if (bad != 0) mismatched++;
    axi_wr_rd(32'h00, 32'hFFFF_FF99, 32'h00, br, d, rr);
    compared++;
    if (br !== 2'b00 || d !== 32'h0 || rr !== 2'b00) begin
      mismatched++; $display("FAIL empty_joint: got bresp=%b rdata=%h rresp=%b required 00/00000000/00", br, d, rr);
    end
    axi_read(32'h00, d, rr);
    compared++;
    if (d !== 32'h99) begin mismatched++; $display("FAIL empty_joint_stored: got %h required 00000099", d); end
    pulse_ack(2'b11);
  endtask

  task automatic test_flush();
    logic [31:0] d; logic [1:0] r;
    axi_write(32'h0C, 32'h00, r);
    axi_write(32'h00, 32'h11, r);
    axi_write(32'h00, 32'h22, r);
    axi_write(32'h04, 32'h33, r);
    axi_write(32'h04, 32'h44, r);
    axi_read(32'h08, d, r);
    compared++;
    if (d !== 32'h0202_0001) begin mismatched++; $display("FAIL preflush_status: got %h required 02020001", d); end
    pulse_ack(2'b11);
    compared++;
    if (int_core !== 1'b0 || int_xdma !== 1'b0) begin
      mismatched++; $display("FAIL preflush_irqs: got %b%b required 00", int_core, int_xdma);
    end
    axi_write(32'h0C, 32'h13, r);
    repeat (2) @(negedge clk);
    compared++;
    if (int_core !== 1'b0 || int_xdma !== 1'b0) begin
      mismatched++; $display("FAIL flush_irqs: got %b%b required 00", int_core, int_xdma);
    end
    axi_read(32'h08, d, r);
    compared++;
    if (d !== 32'h0000_0014) begin mismatched++; $display("FAIL flush_status: got %h required 00000014", d); end
    axi_read(32'h00, d, r);
    compared++;
    if (d !== 32'h0 || r !== 2'b00) begin mismatched++; $display("FAIL flush_rx_read: got %h/%b required 0/00", d, r); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d; logic [1:0] r;
    axi_read(32'h18, d, r);
    compared++;
    if (d !== 32'h0 || r !== 2'b10) begin mismatched++; $display("FAIL unmapped_read: got %h/%b required 0/10", d, r); end
    axi_write(32'h1C, 32'h5A, r);
    compared++;
    if (r !== 2'b10) begin mismatched++; $display("FAIL unmapped_write: got %b required 10", r); end
    axi_write(32'h08, 32'hFFFF_FFFF, r);
    compared++;
    if (r !== 2'b00) begin mismatched++; $display("FAIL status_write: got %b required 00", r); end
    axi_read(32'h08, d, r);
    compared++;
    if (d !== 32'h0000_0014) begin mismatched++; $display("FAIL status_after_write: got %h required 00000014", d); end
    axi_read(32'h0C, d, r);
    compared++;
    if (d !== 32'h0 || r !== 2'b00) begin mismatched++; $display("FAIL control_read: got %h/%b required 0/00", d, r); end
  endtask

  task automatic test_reset_mid_txn();
    logic [31:0] d; logic [1:0] r;
    int n;
    @(negedge clk);
    bus.awaddr = 32'h04; bus.wdata = 32'h66; bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 20) begin @(negedge clk); n++; end
    compared++;
    if (bus.bvalid !== 1'b1) begin mismatched++; $display("FAIL midreset_bvalid_before: got %b required 1", bus.bvalid); end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (bus.bvalid !== 1'b0 || int_xdma !== 1'b0) begin
      mismatched++; $display("FAIL midreset_drop: got bvalid=%b xdma=%b required 0/0", bus.bvalid, int_xdma);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.bready = 1'b1;
    axi_read(32'h08, d, r);
    compared++;
    if (d !== 32'h0000_0004) begin mismatched++; $display("FAIL midreset_status: got %h required 00000004", d); end
  endtask

  initial begin
    test_reset();
    test_tx_path();
    test_rx_overrun();
    test_back_to_back();
    test_flush();
    test_unmapped();
    test_reset_mid_txn();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
